seg7_scan_mux: RTL
==================

# seg7_scan_mux

Parametrised multiplexed 7-segment display scanner; successor to the two-digit scanner, generalised to DIGITS digits with per-digit enable mask, one-hot digit-select outputs, frame tick and synchronous blanking. Sits between the display-data formatting logic and the board display pins. It time-division-multiplexes one shared segment bus across all enabled digits at a fixed dwell of FREQ+1 clock cycles per digit.

## Interface
- DIGITS, 4: number of multiplexed digits, 2..16.
- FREQ, 250: dwell length minus one, in clk cycles. Must satisfy FREQ < 2**CBITS, otherwise elaboration error.
- CBITS, 8: dwell counter width.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- segs  input  7*DIGITS  packed segment patterns; digit i at [7i+6:7i].
- digit_en  input  DIGITS  per-digit enable mask; 0 = digit skipped in scan.
- blank  input  1  synchronous blank; forces segment and anode to 0.
- segment  output  7  pattern of the currently selected digit.
- anode  output  DIGITS  one-hot select of the current digit; all-zero when dark.
- frame_tick  output  1  one-cycle pulse when the scan wraps to a lower-or-equal digit index.

## Operation
- Reset values: cnt=0, idx=DIGITS-1, segment=0, anode=0, frame_tick=0.
- Dwell counter: if cnt<FREQ then cnt+1, else cnt=0 and a switch event occurs.
- At a switch event, nxt is the first enabled index cyclically after idx, searching idx+1 .. DIGITS-1, 0 .. idx. This includes idx itself when it is the only enabled digit.
- On a switch with some digit enabled:
  - idx<=nxt, segment<=segs slice nxt, anode<=onehot(nxt).
  - frame_tick<=1 iff nxt<=idx.
- On a switch with digit_en==0: segment<=0, anode<=0, idx held, no frame_tick.
- segs and digit_en are sampled only at switch events. Changes mid-dwell take effect at the next switch.
- blank=1: segment and anode read 0 from the next cycle on, while cnt, idx and frame_tick keep running. When blank is deasserted, outputs show the current idx's latched pattern from the next cycle.
- No combinational path from any input to any output.

## Timing
- First digit (index 0 if enabled) appears FREQ+1 cycles after rst deasserts, with frame_tick high in that same cycle.
- Each digit is displayed for exactly FREQ+1 cycles. A full frame of k enabled digits lasts k*(FREQ+1) cycles.
- frame_tick is high for exactly 1 cycle per frame.
- rst mid-dwell clears all outputs immediately (asynchronous). Scanning restarts from the reset state.
- blank latency: 1 cycle assert, 1 cycle release.

## Configuration
- SEG7_DIM_EN defined:
  - Adds input port brightness [CBITS-1:0].
  - anode is forced to 0 in every cycle where cnt >= brightness. The gating is applied from registered cnt and brightness.
  - brightness >= FREQ+1 gives full on; brightness=0 keeps the display dark while scanning continues.
  - segment and frame_tick are unaffected.
- SEG7_DIM_EN undefined: no brightness port; anode is driven for the full dwell.

## Structure
- Package seg7_pkg:
  - SEG_W=7 and typedef seg_t (logic [SEG_W-1:0]).
  - onehot function and blank-pattern constant SEG_OFF.
- Sub-module seg7_next_digit: combinational rotating priority search (idx, digit_en -> nxt, any_en, wrap). Instantiated once.

## Test plan
All scenarios use DIGITS=4, FREQ=3, CBITS=8.
- Reset release, segs=0x0_..distinct, digit_en=4'b1111:
  - anode=0001 at cycle 4, then 0010 at 8, 0100 at 12, 1000 at 16, 0001 at 20.
  - frame_tick at 4 and 20; segment matches each slice.
- digit_en=4'b0101: anode alternates 0001/0100 every 4 cycles; frame_tick every 8 cycles.
- digit_en=4'b0100 only: anode stays 0100; frame_tick every 4 cycles.
- digit_en=0 at a switch: segment=0 and anode=0, no frame_tick. Restoring 4'b0001 gives anode=0001 at the next switch, with tick.
- rst pulsed mid-dwell: outputs 0 in the same cycle; first digit reappears 4 cycles after release. blank=1 for 6 cycles: outputs 0, idx keeps advancing, display resumes on the correct digit.
- SEG7_DIM_EN, brightness=2: anode active 2 of every 4 cycles. brightness=0: anode always 0 while frame_tick continues.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 16;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = '0;

  // One-hot decode of a digit index, sized for the largest supported scanner.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: display-data side bundle for seg7_scan_mux.
// The brightness field exists only when SEG7_DIM_EN is defined.
interface seg7_scan_mux_if #(
  parameter int unsigned DIGITS = 4
`ifdef SEG7_DIM_EN
  ,
  parameter int unsigned CBITS  = 8
`endif
);
  import seg7_pkg::*;

  logic [SEG_W*DIGITS-1:0] segs;
  logic [DIGITS-1:0]       digit_en;
  logic                    blank;
`ifdef SEG7_DIM_EN
  logic [CBITS-1:0]        brightness;
`endif
  seg_t                    segment;
  logic [DIGITS-1:0]       anode;
  logic                    frame_tick;

  // Formatting logic that supplies patterns and observes the scan.
  modport master (
    output segs, digit_en, blank,
`ifdef SEG7_DIM_EN
    output brightness,
`endif
    input  segment, anode, frame_tick
  );

  // The scanner itself.
  modport slave (
    input  segs, digit_en, blank,
`ifdef SEG7_DIM_EN
    input  brightness,
`endif
    output segment, anode, frame_tick
  );

endinterface

// File: rtl/seg7_next_digit.sv
// seg7_next_digit: rotating priority search for the next enabled digit,
// scanning idx+1 .. DIGITS-1, 0 .. idx. Purely combinational.
module seg7_next_digit #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IW     = 2
) (
  input  logic [IW-1:0]     i_idx,
  input  logic [DIGITS-1:0] i_digit_en,
  output logic [IW-1:0]     o_nxt,
  output logic              o_any,
  output logic              o_wrap
);

  logic        w_found;
  int unsigned w_cand;

  // First enabled index after i_idx, wrapping; i_idx itself is tried last.
  always_comb begin
    o_nxt   = i_idx;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= DIGITS; k++) begin
      w_cand = (32'(i_idx) + k) % DIGITS;
      if (!w_found && i_digit_en[IW'(w_cand)]) begin
        o_nxt   = IW'(w_cand);
        w_found = 1'b1;
      end
    end
    o_any  = |i_digit_en;
    o_wrap = (o_nxt <= i_idx);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-division multiplexer driving one shared 7-segment bus
// across DIGITS digits with a dwell of FREQ+1 clocks per enabled digit.
// Optional macro SEG7_DIM_EN adds a brightness input that gates the anode
// to the first `brightness` cycles of every dwell.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned FREQ   = 250,
  parameter int unsigned CBITS  = 8
) (
  input  logic          clk,
  input  logic          rst,
  seg7_scan_mux_if.slave bus
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (64'(FREQ) >= (64'd1 << CBITS)) begin : g_freq_chk
    $error("seg7_scan_mux: FREQ must be smaller than 2**CBITS");
  end
  if (DIGITS < 2 || DIGITS > MAX_DIGITS) begin : g_digits_chk
    $error("seg7_scan_mux: DIGITS must be within 2..16");
  end

  logic [CBITS-1:0]  r_cnt;
  logic [IW-1:0]     r_idx;
  seg_t              r_pat;
  logic [DIGITS-1:0] r_sel;
  seg_t              r_segment;
  logic [DIGITS-1:0] r_anode;
  logic              r_tick;

  logic [IW-1:0]     w_nxt;
  logic              w_any;
  logic              w_wrap;
  logic              w_switch;
  seg_t              w_pat_nxt;
  logic [DIGITS-1:0] w_sel_nxt;

  seg7_next_digit #(
    .DIGITS (DIGITS),
    .IW     (IW)
  ) u_next (
    .i_idx      (r_idx),
    .i_digit_en (bus.digit_en),
    .o_nxt      (w_nxt),
    .o_any      (w_any),
    .o_wrap     (w_wrap)
  );

  // Latched pattern/select for the current digit; only changes at a switch.
  always_comb begin
    w_switch  = !(r_cnt < CBITS'(FREQ));
    w_pat_nxt = r_pat;
    w_sel_nxt = r_sel;
    if (w_switch) begin
      if (w_any) begin
        w_pat_nxt = bus.segs[32'(w_nxt)*SEG_W +: SEG_W];
        w_sel_nxt = DIGITS'(onehot(4'(w_nxt)));
      end else begin
        w_pat_nxt = SEG_OFF;
        w_sel_nxt = '0;
      end
    end
  end

  // Dwell counter, scan index and registered outputs. The latched pair
  // r_pat/r_sel is kept apart from the output registers so that blanking
  // only masks the outputs and release restores the current digit at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= IW'(DIGITS-1);
      r_pat     <= SEG_OFF;
      r_sel     <= '0;
      r_segment <= SEG_OFF;
      r_anode   <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt <= w_switch ? '0 : r_cnt + 1'b1;
      if (w_switch && w_any) begin
        r_idx <= w_nxt;
      end
      r_pat     <= w_pat_nxt;
      r_sel     <= w_sel_nxt;
      r_segment <= bus.blank ? SEG_OFF : w_pat_nxt;
      r_anode   <= bus.blank ? '0 : w_sel_nxt;
      r_tick    <= w_switch && w_any && w_wrap;
    end
  end

  assign bus.segment    = r_segment;
  assign bus.frame_tick = r_tick;

`ifdef SEG7_DIM_EN
  logic [CBITS-1:0] r_bright;

  // Registered brightness so the anode gate depends only on flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else begin
      r_bright <= bus.brightness;
    end
  end

  assign bus.anode = r_anode & {DIGITS{r_cnt < r_bright}};
`else
  assign bus.anode = r_anode;
`endif

endmodule
